muxbus_mem_slave: RTL
=====================

Name: muxbus_mem_slave

Overview:
Synthesizable slave memory/IO model for the multiplexed address/data bus of the AS2650 core. It is the successor to the bench-only latch+RAM model.
- Address is latched byte-wise from the shared bus under per-byte LE strobes.
- Reads are served from an internal array with a parametrised number of wait states.
- Writes commit on the WEb rising edge.
- A separate small register file answers IO-space cycles.
- Everything is sampled on one clock, so the block can run in FPGA emulation as well as simulation.

Parameters:
DATA_W, 8, bus/data width in bits
ADDR_BYTES, 2, number of address bytes latched (address width = DATA_W*ADDR_BYTES)
MEM_AW, 12, log2 of memory depth; upper address bits ignored (aliasing)
WAIT_STATES, 1, clock cycles between read start and data valid (0..15)
IO_AW, 2, log2 of IO register count
WPROT_LIMIT, 256, first writable address when write-protect is compiled in

Ports:
wb_clk_i  in  1  clock; all inputs sampled on rising edge
wb_rst_i  in  1  asynchronous, active-high reset
bus_out  in  DATA_W  address/data driven by CPU
le  in  ADDR_BYTES  latch enable per address byte; bit 0 = low byte
oeb  in  1  read strobe, active low
web  in  1  write strobe, active low
io_sel  in  1  1 = IO space cycle (IOD/IOC), 0 = memory
bus_in  out  DATA_W  read data to CPU; 0 when not driving
bus_oe  out  1  1 while bus_in is valid
ready  out  1  0 while a read is in its wait states
io_regs  out  DATA_W<<IO_AW  flattened IO register file; reg 0 at LSBs
err  out  1  sticky: oeb and web low together seen
wp_hit  out  1  one-cycle pulse on dropped protected write

Behaviour:
- Reset values: bus_in=0, bus_oe=0, ready=1, err=0, wp_hit=0, io_regs=0, address latch=0, FSM=IDLE, sampled oeb/web=1. Memory contents are not reset.
- Address latch:
  - Each cycle with le[i]=1, byte i of the latch <= bus_out. Bytes with le[i]=0 hold.
  - Multiple le bits high in one cycle load the same bus value into each byte.
  - The latch is frozen while FSM is not IDLE.
- Indexing:
  - Memory index = latch[MEM_AW-1:0]; higher addresses wrap.
  - IO index = latch[IO_AW-1:0].
- Edge detect: registered copies oeb_q and web_q. Read start = oeb==0 && oeb_q==1. Write commit = web==1 && web_q==0.
- Write data: a data register captures bus_out every cycle web==0. On commit, that value is written to mem[index] (io_sel=0) or io_regs[index] (io_sel=1). io_sel is sampled on the commit cycle.
- Read FSM:
  - IDLE: on read start, load cnt=WAIT_STATES and capture io_sel. If WAIT_STATES==0 go to DRIVE, else go to WAIT with ready=0.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, fetch data and go to DRIVE. If oeb returns high, abort to IDLE, ready=1, no drive.
  - DRIVE: bus_in = fetched data, bus_oe=1, ready=1. Stay while oeb==0. On oeb==1, next cycle bus_oe=0, bus_in=0, go to IDLE.
  - Latency read start -> bus_oe: WAIT_STATES+1 cycles.
- Simultaneous oeb==0 and web==0 in any cycle:
  - err is set (sticky until reset).
  - The read is not started; an active read aborts to IDLE.
  - The write still commits on the web rising edge.
- Write to the address being driven in DRIVE: memory updates; bus_in keeps the already fetched value.
- Reset asserted mid-cycle: immediate return to reset values. A write in flight is lost.

Optional Feature:
MUXBUS_WPROT_EN
- Defined: memory writes with full latched address < WPROT_LIMIT are dropped, and wp_hit pulses high for the commit cycle. IO writes are never protected.
- Undefined: all writes commit; wp_hit is tied 0; WPROT_LIMIT is unused.

Test Plan:
- Reset: assert wb_rst_i with no clock edge -> bus_oe=0, ready=1, err=0, io_regs=0 immediately.
- Write 8'hA5 at 16'h0123: le=2'b10 with bus=8'h01, then le=2'b01 with bus=8'h23, web low 2 cycles with bus=8'hA5, then web high. Read with WAIT_STATES=1 -> ready=0 for 1 cycle, bus_oe=1 with bus_in=8'hA5 on cycle 2 after oeb falls.
- Aliasing: write 8'h3C to 16'h1123 with MEM_AW=12; read 16'h0123 -> 8'h3C.
- IO space: io_sel=1, write 8'h77 to address 2 -> io_regs[23:16]=8'h77. Read it back -> 8'h77; memory at address 2 unchanged.
- Abort and conflict:
  - oeb pulled high during WAIT -> no bus_oe pulse, ready back to 1.
  - oeb and web low together -> err=1 and stays set until reset.
- Write protect (MUXBUS_WPROT_EN, WPROT_LIMIT=256):
  - Write to 16'h0010 -> wp_hit pulse, memory unchanged.
  - Write to 16'h0100 -> committed, no pulse.
  - Without the macro -> both writes committed.

Source files
------------

// File: rtl/muxbus_mem_slave_if.sv
// Multiplexed address/data bus between the AS2650 CPU (master) and a memory/IO slave.
// Latency: none, wires only; timing is owned by the slave.
// Backpressure: the slave drops ready while a read is in its wait states.
interface muxbus_mem_slave_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_BYTES = 2,
  parameter int IO_AW      = 2
);
  logic [DATA_W-1:0]          bus_out;
  logic [ADDR_BYTES-1:0]      le;
  logic                       oeb;
  logic                       web;
  logic                       io_sel;
  logic [DATA_W-1:0]          bus_in;
  logic                       bus_oe;
  logic                       ready;
  logic [(DATA_W<<IO_AW)-1:0] io_regs;
  logic                       err;
  logic                       wp_hit;

  modport master (
    output bus_out, le, oeb, web, io_sel,
    input  bus_in, bus_oe, ready, io_regs, err, wp_hit
  );

  modport slave (
    input  bus_out, le, oeb, web, io_sel,
    output bus_in, bus_oe, ready, io_regs, err, wp_hit
  );
endinterface

// File: rtl/muxbus_mem_slave.sv
// Slave memory + IO register file on the AS2650 muxed bus; byte-wise address latch, write on WEb rise.
// Latency: read start (oeb fall sampled) to bus_oe = WAIT_STATES+1 cycles; writes commit on the cycle web is seen high again.
// Backpressure: ready=0 during read wait states; optional write protection via `define MUXBUS_WPROT_EN.
module muxbus_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_BYTES  = 2,
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 1,
  parameter int IO_AW       = 2,
  parameter int WPROT_LIMIT = 256
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  muxbus_mem_slave_if.slave bus
);

  localparam int AW  = DATA_W * ADDR_BYTES;
  localparam int NIO = 1 << IO_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [3:0]                  r_cnt, w_cnt_nxt;
  logic                        r_io_rd, w_io_rd_nxt;
  logic [DATA_W-1:0]           r_rdata, w_rdata_nxt;
  logic [AW-1:0]               r_addr;
  logic                        r_oeb_q, r_web_q;
  logic [DATA_W-1:0]           r_wdata;
  logic [NIO-1:0][DATA_W-1:0]  r_io;
  logic                        r_err, r_wp_hit;
  logic [DATA_W-1:0]           r_mem [0:(1<<MEM_AW)-1];

  logic              w_conflict, w_rd_start, w_commit, w_wp_block;
  logic [MEM_AW-1:0] w_mem_idx;
  logic [IO_AW-1:0]  w_io_idx;
  logic              w_unused_addr;

  // A cycle with both strobes low is a bus conflict: it blocks read starts and aborts active reads.
  assign w_conflict = ~bus.oeb & ~bus.web;
  assign w_rd_start = ~bus.oeb & r_oeb_q & bus.web;
  assign w_commit   = bus.web & ~r_web_q;
  assign w_mem_idx  = r_addr[MEM_AW-1:0];
  assign w_io_idx   = r_addr[IO_AW-1:0];
  // Address bits above MEM_AW only matter to write protection; memory aliases over them.
  assign w_unused_addr = ^r_addr;

`ifdef MUXBUS_WPROT_EN
  assign w_wp_block = w_commit & ~bus.io_sel & (r_addr < AW'(WPROT_LIMIT));
`else
  assign w_wp_block = 1'b0;
`endif

  assign bus.bus_oe  = (r_state == ST_DRIVE);
  assign bus.bus_in  = (r_state == ST_DRIVE) ? r_rdata : '0;
  assign bus.ready   = (r_state != ST_WAIT);
  assign bus.io_regs = r_io;
  assign bus.err     = r_err;
  assign bus.wp_hit  = r_wp_hit;

  // Read FSM next state: wait-state countdown, fetch on the last wait cycle, abort on oeb rise or conflict.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_io_rd_nxt = r_io_rd;
    w_rdata_nxt = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_start) begin
          w_cnt_nxt   = 4'(WAIT_STATES);
          w_io_rd_nxt = bus.io_sel;
          if (WAIT_STATES == 0) begin
            w_rdata_nxt = bus.io_sel ? r_io[w_io_idx] : r_mem[w_mem_idx];
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.oeb || w_conflict) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_rdata_nxt = r_io_rd ? r_io[w_io_idx] : r_mem[w_mem_idx];
          w_state_nxt = ST_DRIVE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (bus.oeb || w_conflict) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM state, countdown and fetched data registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_io_rd <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_io_rd <= w_io_rd_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Strobe history for edge detection and write data capture while web is low.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_oeb_q <= 1'b1;
      r_web_q <= 1'b1;
      r_wdata <= '0;
    end else begin
      r_oeb_q <= bus.oeb;
      r_web_q <= bus.web;
      if (!bus.web) begin
        r_wdata <= bus.bus_out;
      end
    end
  end

  // Byte-wise address latch; frozen while a read is in progress so the fetch index is stable.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_addr <= '0;
    end else if (r_state == ST_IDLE) begin
      for (int i = 0; i < ADDR_BYTES; i++) begin
        if (bus.le[i]) begin
          r_addr[i*DATA_W +: DATA_W] <= bus.bus_out;
        end
      end
    end
  end

  // IO register writes, sticky conflict flag and protected-write pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_io     <= '0;
      r_err    <= 1'b0;
      r_wp_hit <= 1'b0;
    end else begin
      if (w_commit && bus.io_sel) begin
        r_io[w_io_idx] <= r_wdata;
      end
      if (w_conflict) begin
        r_err <= 1'b1;
      end
      r_wp_hit <= w_wp_block;
    end
  end

  // Memory array writes; contents survive reset, and web_q resets high so no commit fires during reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_commit && !bus.io_sel && !w_wp_block) begin
      r_mem[w_mem_idx] <= r_wdata;
    end
  end

endmodule
